// File: rtl/conv_pkg.sv
// Shared widths, the data type and the 10-bit reduction helper for the conv MAC.
// Defining CONV_SAT_EN makes every 10-bit reduction saturate; otherwise it wraps.
package conv_pkg;

    localparam int DATA_W     = 10;
    localparam int TAPS       = 9;
    localparam int FRAC_SHIFT = 10;
    localparam int PROD_W     = 20;
    localparam int ACC_W      = 24;
    localparam int RES_W      = ACC_W - FRAC_SHIFT;
    localparam int MERGE_W    = 16;
    localparam int BUS_W      = DATA_W * TAPS;

    typedef logic signed [DATA_W-1:0] data_t;

    localparam data_t                     DATA_MAX  = 10'sh1FF;
    localparam data_t                     DATA_MIN  = 10'sh200;
    localparam logic signed [MERGE_W-1:0] LIMIT_MAX = 16'sd511;
    localparam logic signed [MERGE_W-1:0] LIMIT_MIN = -16'sd512;

    function automatic data_t sat_or_wrap10(input logic signed [MERGE_W-1:0] x);
        data_t r;
`ifdef CONV_SAT_EN
        if (x > LIMIT_MAX)
            r = DATA_MAX;
        else if (x < LIMIT_MIN)
            r = DATA_MIN;
        else
            r = x[DATA_W-1:0];
`else
        r = x[DATA_W-1:0];
`endif
        return r;
    endfunction

endpackage

// File: rtl/conv_dot9.sv
// Combinational 9-tap signed dot product of one lane, floor-rescaled by 2^-FRAC_SHIFT.
module conv_dot9
    import conv_pkg::*;
(
    input  logic [BUS_W-1:0]        pixels,
    input  logic [BUS_W-1:0]        weights,
    output logic signed [RES_W-1:0] result
);

    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] prod;
    logic                     unused_frac;

    // Nine 20-bit products sum into 24 bits without any chance of overflow.
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int k = 0; k < TAPS; k++) begin
            prod = $signed(pixels[k*DATA_W +: DATA_W]) * $signed(weights[k*DATA_W +: DATA_W]);
            acc  = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    // Dropping the low bits of a two's-complement value is an arithmetic shift, i.e. floor.
    assign result      = acc[ACC_W-1:FRAC_SHIFT];
    assign unused_frac = ^acc[FRAC_SHIFT-1:0];

endmodule

// File: rtl/conv.sv
// Three-lane 3x3 convolution MAC with per-lane or merged output and a one-cycle register stage.
// The 10-bit reductions saturate when CONV_SAT_EN is defined and wrap otherwise.
module conv
    import conv_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic                     i_opcode,
    input  logic [BUS_W-1:0]         i_busData0,
    input  logic [BUS_W-1:0]         i_busData1,
    input  logic [BUS_W-1:0]         i_busData2,
    input  logic [BUS_W-1:0]         i_busWeight0,
    input  logic [BUS_W-1:0]         i_busWeight1,
    input  logic [BUS_W-1:0]         i_busWeight2,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_data0,
    output logic signed [DATA_W-1:0] o_data1,
    output logic signed [DATA_W-1:0] o_data2
);

    logic signed [RES_W-1:0]   r0;
    logic signed [RES_W-1:0]   r1;
    logic signed [RES_W-1:0]   r2;
    logic signed [MERGE_W-1:0] merged;
    data_t                     next_d0;
    data_t                     next_d1;
    data_t                     next_d2;

    conv_dot9 u_lane0 (.pixels(i_busData0), .weights(i_busWeight0), .result(r0));
    conv_dot9 u_lane1 (.pixels(i_busData1), .weights(i_busWeight1), .result(r1));
    conv_dot9 u_lane2 (.pixels(i_busData2), .weights(i_busWeight2), .result(r2));

    // Merging adds the already-shifted lane results, so each lane floors independently.
    always_comb begin
        merged = MERGE_W'(r0) + MERGE_W'(r1) + MERGE_W'(r2);
        if (i_opcode) begin
            next_d0 = sat_or_wrap10(MERGE_W'(r0));
            next_d1 = sat_or_wrap10(MERGE_W'(r1));
            next_d2 = sat_or_wrap10(MERGE_W'(r2));
        end else begin
            next_d0 = sat_or_wrap10(merged);
            next_d1 = '0;
            next_d2 = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data0 <= '0;
            o_data1 <= '0;
            o_data2 <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_data0 <= next_d0;
                o_data1 <= next_d1;
                o_data2 <= next_d2;
            end
        end
    end

endmodule

// File: tb/tb_conv.sv
// Directed self-checking bench for conv; expected values are hand-computed lane dot products.
module tb_conv;
    import conv_pkg::*;

    logic                     clk;
    logic                     reset;
    logic                     valid;
    logic                     opcode;
    logic [BUS_W-1:0]         d0, d1, d2, w0, w1, w2;
    logic                     o_valid;
    logic signed [DATA_W-1:0] o_data0, o_data1, o_data2;

    int tests_run;
    int tests_failed;

    conv dut (
        .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_opcode(opcode),
        .i_busData0(d0), .i_busData1(d1), .i_busData2(d2),
        .i_busWeight0(w0), .i_busWeight1(w1), .i_busWeight2(w2),
        .o_valid(o_valid), .o_data0(o_data0), .o_data1(o_data1), .o_data2(o_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BUS_W-1:0] pack_all(input int v);
        logic [BUS_W-1:0] r;
        logic [31:0] t;
        t = v;
        for (int k = 0; k < TAPS; k++) r[k*DATA_W +: DATA_W] = t[DATA_W-1:0];
        return r;
    endfunction

    function automatic logic [BUS_W-1:0] pack9(input int a0, input int a1, input int a2,
                                               input int a3, input int a4, input int a5,
                                               input int a6, input int a7, input int a8);
        logic [31:0] t [TAPS];
        logic [BUS_W-1:0] r;
        t[0] = a0; t[1] = a1; t[2] = a2; t[3] = a3; t[4] = a4;
        t[5] = a5; t[6] = a6; t[7] = a7; t[8] = a8;
        for (int k = 0; k < TAPS; k++) r[k*DATA_W +: DATA_W] = t[k][DATA_W-1:0];
        return r;
    endfunction

    // Present one operand set, clock it in, then settle just past the edge.
    task automatic drive_cycle(input logic v, input logic op);
        valid  = v;
        opcode = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        valid = 1'b1;
        opcode = 1'b1;
        d0 = pack_all(100); w0 = pack_all(50);
        d1 = pack_all(100); w1 = pack_all(50);
        d2 = pack_all(100); w2 = pack_all(50);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (o_valid !== 1'b0 || o_data0 !== 10'sd0 || o_data1 !== 10'sd0 || o_data2 !== 10'sd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_with_valid: got v=%b %0d %0d %0d, want v=0 0 0 0",
                     o_valid, o_data0, o_data1, o_data2);
        end
        reset = 1'b0;
        drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b0, 1'b1);
        tests_run++;
        if (o_valid !== 1'b0 || o_data0 !== 10'sd0 || o_data1 !== 10'sd0 || o_data2 !== 10'sd0) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset: got v=%b %0d %0d %0d, want v=0 0 0 0",
                     o_valid, o_data0, o_data1, o_data2);
        end
    endtask

    task automatic test_lanes_positive;
        d0 = pack_all(100); w0 = pack_all(50);
        d1 = pack_all(200); w1 = pack_all(60);
        d2 = pack_all(250); w2 = pack_all(65);
        drive_cycle(1'b1, 1'b1);
        tests_run++;
        if (o_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pos_valid: got %b, want 1", o_valid);
        end
        tests_run++;
        if (o_data0 !== 10'sd43) begin
            tests_failed++;
            $display("[TB] FAIL pos_lane0: got %0d, want 43", o_data0);
        end
        tests_run++;
        if (o_data1 !== 10'sd105) begin
            tests_failed++;
            $display("[TB] FAIL pos_lane1: got %0d, want 105", o_data1);
        end
        tests_run++;
        if (o_data2 !== 10'sd142) begin
            tests_failed++;
            $display("[TB] FAIL pos_lane2: got %0d, want 142", o_data2);
        end
    endtask

    task automatic test_lanes_negative;
        d0 = pack_all(-100); w0 = pack_all(50);
        d1 = pack_all(-150); w1 = pack_all(100);
        d2 = pack9(-250, -250, 250, 250, -150, -150, -150, -150, -150); w2 = pack_all(100);
        drive_cycle(1'b1, 1'b1);
        tests_run++;
        if (o_data0 !== -10'sd44) begin
            tests_failed++;
            $display("[TB] FAIL neg_lane0: got %0d, want -44", o_data0);
        end
        tests_run++;
        if (o_data1 !== -10'sd132) begin
            tests_failed++;
            $display("[TB] FAIL neg_lane1: got %0d, want -132", o_data1);
        end
        tests_run++;
        if (o_data2 !== -10'sd74) begin
            tests_failed++;
            $display("[TB] FAIL neg_lane2: got %0d, want -74", o_data2);
        end
        d2 = pack_all(-256); w2 = pack_all(1);
        drive_cycle(1'b1, 1'b1);
        tests_run++;
        if (o_data2 !== -10'sd3) begin
            tests_failed++;
            $display("[TB] FAIL neg_floor_small: got %0d, want -3", o_data2);
        end
    endtask

    task automatic test_mixed;
        d0 = pack9(200, -50, 100, -150, 255, -256, 0, 75, -200);
        w0 = pack9(30, -40, 50, -60, 70, -80, 90, -100, 110);
        drive_cycle(1'b1, 1'b1);
        tests_run++;
        if (o_data0 !== 10'sd30) begin
            tests_failed++;
            $display("[TB] FAIL mixed_lane0: got %0d, want 30", o_data0);
        end
    endtask

    task automatic test_merge;
        d0 = pack_all(100); w0 = pack_all(50);
        d1 = pack_all(200); w1 = pack_all(60);
        d2 = pack_all(250); w2 = pack_all(65);
        drive_cycle(1'b1, 1'b0);
        tests_run++;
        if (o_data0 !== 10'sd290 || o_data1 !== 10'sd0 || o_data2 !== 10'sd0) begin
            tests_failed++;
            $display("[TB] FAIL merge_pos: got %0d %0d %0d, want 290 0 0", o_data0, o_data1, o_data2);
        end
        d0 = pack_all(-100); w0 = pack_all(50);
        d1 = pack_all(-150); w1 = pack_all(100);
        d2 = pack9(-250, -250, 250, 250, -150, -150, -150, -150, -150); w2 = pack_all(100);
        drive_cycle(1'b1, 1'b0);
        tests_run++;
        if (o_data0 !== -10'sd250 || o_data1 !== 10'sd0 || o_data2 !== 10'sd0) begin
            tests_failed++;
            $display("[TB] FAIL merge_neg: got %0d %0d %0d, want -250 0 0", o_data0, o_data1, o_data2);
        end
    endtask

    task automatic test_overflow;
        data_t exp_lane;
        data_t exp_merge;
`ifdef CONV_SAT_EN
        exp_lane  = 10'sd511;
        exp_merge = 10'sd511;
`else
        exp_lane  = -10'sd453;
        exp_merge = -10'sd335;
`endif
        d0 = pack_all(255); w0 = pack_all(255);
        d1 = pack_all(255); w1 = pack_all(255);
        d2 = pack_all(255); w2 = pack_all(255);
        drive_cycle(1'b1, 1'b1);
        tests_run++;
        if (o_data0 !== exp_lane || o_data1 !== exp_lane || o_data2 !== exp_lane) begin
            tests_failed++;
            $display("[TB] FAIL overflow_lanes: got %0d %0d %0d, want %0d each",
                     o_data0, o_data1, o_data2, exp_lane);
        end
        drive_cycle(1'b1, 1'b0);
        tests_run++;
        if (o_data0 !== exp_merge) begin
            tests_failed++;
            $display("[TB] FAIL overflow_merge: got %0d, want %0d", o_data0, exp_merge);
        end
    endtask

    task automatic test_hold_and_latency;
        d0 = pack_all(100); w0 = pack_all(50);
        d1 = pack_all(200); w1 = pack_all(60);
        d2 = pack_all(250); w2 = pack_all(65);
        drive_cycle(1'b1, 1'b1);
        d0 = pack_all(-100); d1 = pack_all(-150); d2 = pack_all(-256);
        drive_cycle(1'b0, 1'b0);
        tests_run++;
        if (o_valid !== 1'b0 || o_data0 !== 10'sd43 || o_data1 !== 10'sd105 || o_data2 !== 10'sd142) begin
            tests_failed++;
            $display("[TB] FAIL hold: got v=%b %0d %0d %0d, want v=0 43 105 142",
                     o_valid, o_data0, o_data1, o_data2);
        end
        d0 = pack_all(-100); w0 = pack_all(50);
        valid = 1'b1;
        opcode = 1'b1;
        #2;
        tests_run++;
        if (o_valid !== 1'b0 || o_data0 !== 10'sd43) begin
            tests_failed++;
            $display("[TB] FAIL latency_before_edge: got v=%b d0=%0d, want v=0 d0=43", o_valid, o_data0);
        end
        @(posedge clk); #1;
        tests_run++;
        if (o_valid !== 1'b1 || o_data0 !== -10'sd44) begin
            tests_failed++;
            $display("[TB] FAIL latency_pulse: got v=%b d0=%0d, want v=1 d0=-44", o_valid, o_data0);
        end
        drive_cycle(1'b0, 1'b1);
        tests_run++;
        if (o_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL latency_single: got v=%b, want 0", o_valid);
        end
    endtask

    task automatic test_back_to_back;
        d0 = pack_all(100); w0 = pack_all(50);
        drive_cycle(1'b1, 1'b1);
        tests_run++;
        if (o_valid !== 1'b1 || o_data0 !== 10'sd43) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: got v=%b d0=%0d, want v=1 d0=43", o_valid, o_data0);
        end
        d0 = pack_all(-100);
        drive_cycle(1'b1, 1'b1);
        tests_run++;
        if (o_valid !== 1'b1 || o_data0 !== -10'sd44) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: got v=%b d0=%0d, want v=1 d0=-44", o_valid, o_data0);
        end
        reset = 1'b1;
        drive_cycle(1'b1, 1'b1);
        reset = 1'b0;
        tests_run++;
        if (o_valid !== 1'b0 || o_data0 !== 10'sd0 || o_data1 !== 10'sd0 || o_data2 !== 10'sd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wins: got v=%b %0d %0d %0d, want v=0 0 0 0",
                     o_valid, o_data0, o_data1, o_data2);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset  = 1'b1;
        valid  = 1'b0;
        opcode = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        w0 = '0; w1 = '0; w2 = '0;
        #1;
        test_reset();
        test_lanes_positive();
        test_lanes_negative();
        test_mixed();
        test_merge();
        test_overflow();
        test_hold_and_latency();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
